// File: rtl/operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stage_pkg
//  Description : Shared pipeline definitions for the ID->EX operand stage:
//                register label / data widths, the x0 label and the default
//                width of the opaque decoded control bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package operand_stage_pkg;

    localparam int REG_LABEL_W    = 5;
    localparam int XLEN           = 32;
    localparam int CTRL_W_DEFAULT = 16;

    typedef logic [REG_LABEL_W-1:0] reg_label_t;
    typedef logic [XLEN-1:0]        xword_t;

    // Architectural zero register: never a forwarding or hazard source.
    localparam reg_label_t X0_LABEL = '0;

endpackage : operand_stage_pkg
`default_nettype wire

// File: rtl/operand_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fwd_mux
//  Description : Combinational priority select for one source operand.
//                EX-stage result wins over MEM-stage result, which wins over
//                the register file read data. x0 is never forwarded.
//  Ports       : label_i            source register label
//                rf_data_i          register file read data
//                ex_*_i             state of the instruction held in ID/EX
//                ex_result_i        ALU result of that held instruction
//                mem_*_i            MEM-stage destination / write flag / data
//                data_o             resolved operand
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fwd_mux
    import operand_stage_pkg::*;
(
    input  logic [REG_LABEL_W-1:0] label_i,
    input  logic [XLEN-1:0]        rf_data_i,
    input  logic                   ex_valid_i,
    input  logic                   ex_reg_write_i,
    input  logic                   ex_mem_read_i,
    input  logic [REG_LABEL_W-1:0] ex_rd_label_i,
    input  logic [XLEN-1:0]        ex_result_i,
    input  logic                   mem_reg_write_i,
    input  logic [REG_LABEL_W-1:0] mem_rd_label_i,
    input  logic [XLEN-1:0]        mem_result_i,
    output logic [XLEN-1:0]        data_o
);

    logic not_x0;
    logic ex_hit;
    logic mem_hit;

    assign not_x0  = (label_i != X0_LABEL);
    // A load in EX has no data yet; that case is covered by the load-use bubble.
    assign ex_hit  = not_x0 & ex_valid_i & ex_reg_write_i & ~ex_mem_read_i
                   & (ex_rd_label_i == label_i);
    assign mem_hit = not_x0 & mem_reg_write_i & (mem_rd_label_i == label_i);

    always_comb begin
        data_o = rf_data_i;
        if (ex_hit) begin
            data_o = ex_result_i;
        end else if (mem_hit) begin
            data_o = mem_result_i;
        end
    end

endmodule : operand_fwd_mux
`default_nettype wire

// File: rtl/operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stage
//  Description : ID->EX operand stage. Resolves rs1/rs2 through EX/MEM
//                forwarding, inserts a single bubble on load-use hazards and
//                registers operands plus decode payload into the ID/EX
//                register with valid/ready handshake and flush.
//  Ports       : clk_i, rst_i (async, active high)
//                id_*      decode-side instruction and handshake
//                rs*_data_i register file read data (WB already bypassed)
//                ex_result_i / mem_*  forwarding sources
//                ex_ready_i, flush_i  downstream handshake and flush
//                ex_*_o    registered ID/EX contents
//                load_use_stall_o     bubble entering this cycle
//                bubble_cnt_o         saturating load-use bubble count
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_valid_i,
    output logic                   id_ready_o,
    input  logic [REG_LABEL_W-1:0] id_rs1_label_i,
    input  logic [REG_LABEL_W-1:0] id_rs2_label_i,
    input  logic [REG_LABEL_W-1:0] id_rd_label_i,
    input  logic                   id_reg_write_i,
    input  logic                   id_mem_read_i,
    input  logic [XLEN-1:0]        id_pc_i,
    input  logic [XLEN-1:0]        id_imm_i,
    input  logic [CTRL_W-1:0]      id_ctrl_i,
    input  logic [XLEN-1:0]        rs1_data_i,
    input  logic [XLEN-1:0]        rs2_data_i,
    input  logic [XLEN-1:0]        ex_result_i,
    input  logic [REG_LABEL_W-1:0] mem_rd_label_i,
    input  logic                   mem_reg_write_i,
    input  logic [XLEN-1:0]        mem_result_i,
    input  logic                   ex_ready_i,
    input  logic                   flush_i,
    output logic                   ex_valid_o,
    output logic [XLEN-1:0]        ex_rs1_data_o,
    output logic [XLEN-1:0]        ex_rs2_data_o,
    output logic [REG_LABEL_W-1:0] ex_rd_label_o,
    output logic                   ex_reg_write_o,
    output logic                   ex_mem_read_o,
    output logic [XLEN-1:0]        ex_pc_o,
    output logic [XLEN-1:0]        ex_imm_o,
    output logic [CTRL_W-1:0]      ex_ctrl_o,
    output logic                   load_use_stall_o,
    output logic [CNT_W-1:0]       bubble_cnt_o
);

    // ID/EX pipeline register
    logic                   valid_q,     valid_d;
    logic [XLEN-1:0]        rs1_q,       rs1_d;
    logic [XLEN-1:0]        rs2_q,       rs2_d;
    logic [REG_LABEL_W-1:0] rd_q,        rd_d;
    logic                   rw_q,        rw_d;
    logic                   mr_q,        mr_d;
    logic [XLEN-1:0]        pc_q,        pc_d;
    logic [XLEN-1:0]        imm_q,       imm_d;
    logic [CTRL_W-1:0]      ctrl_q,      ctrl_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            load_use;
    logic            slot_free;
    logic            accept;

    operand_fwd_mux u_fwd_rs1 (
        .label_i         (id_rs1_label_i),
        .rf_data_i       (rs1_data_i),
        .ex_valid_i      (valid_q),
        .ex_reg_write_i  (rw_q),
        .ex_mem_read_i   (mr_q),
        .ex_rd_label_i   (rd_q),
        .ex_result_i     (ex_result_i),
        .mem_reg_write_i (mem_reg_write_i),
        .mem_rd_label_i  (mem_rd_label_i),
        .mem_result_i    (mem_result_i),
        .data_o          (rs1_fwd)
    );

    operand_fwd_mux u_fwd_rs2 (
        .label_i         (id_rs2_label_i),
        .rf_data_i       (rs2_data_i),
        .ex_valid_i      (valid_q),
        .ex_reg_write_i  (rw_q),
        .ex_mem_read_i   (mr_q),
        .ex_rd_label_i   (rd_q),
        .ex_result_i     (ex_result_i),
        .mem_reg_write_i (mem_reg_write_i),
        .mem_rd_label_i  (mem_rd_label_i),
        .mem_result_i    (mem_result_i),
        .data_o          (rs2_fwd)
    );

    // Both sources are compared even if the instruction ignores one of them;
    // an occasional unnecessary bubble is cheaper than decoding source usage.
    assign load_use = id_valid_i & valid_q & mr_q & rw_q & (rd_q != X0_LABEL)
                    & ((rd_q == id_rs1_label_i) | (rd_q == id_rs2_label_i));

    assign slot_free        = ~valid_q | ex_ready_i;
    assign id_ready_o       = slot_free & ~load_use & ~flush_i;
    assign accept           = id_valid_i & id_ready_o;
    // Only counts as a bubble when the slot actually advances.
    assign load_use_stall_o = load_use & slot_free;

    always_comb begin
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        mr_d    = mr_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;

        if (flush_i) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
            ctrl_d  = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            rs1_d   = rs1_fwd;
            rs2_d   = rs2_fwd;
            rd_d    = id_rd_label_i;
            rw_d    = id_reg_write_i;
            mr_d    = id_mem_read_i;
            pc_d    = id_pc_i;
            imm_d   = id_imm_i;
            ctrl_d  = id_ctrl_i;
        end else if (load_use_stall_o) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = 1'b0;
        end else if (ex_ready_i & valid_q) begin
            valid_d = 1'b0;
        end

        if (load_use_stall_o && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid_o     = valid_q;
    assign ex_rs1_data_o  = rs1_q;
    assign ex_rs2_data_o  = rs2_q;
    assign ex_rd_label_o  = rd_q;
    assign ex_reg_write_o = rw_q;
    assign ex_mem_read_o  = mr_q;
    assign ex_pc_o        = pc_q;
    assign ex_imm_o       = imm_q;
    assign ex_ctrl_o      = ctrl_q;
    assign bubble_cnt_o   = cnt_q;

endmodule : operand_stage
`default_nettype wire
